// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw inverting buttons in, debounced events and level out.
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] button_n;
    logic [NUM_BUTTONS-1:0] pressed;
    logic [NUM_BUTTONS-1:0] released;
    logic [NUM_BUTTONS-1:0] held;

    modport master (
        output button_n,
        input  pressed,
        input  released,
        input  held
    );

    modport slave (
        input  button_n,
        output pressed,
        output released,
        output held
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-channel two-flop synchronizer plus counter FSM debouncer producing press/release
// pulses and a clean held level.
module button_debouncer #(
    parameter int NUM_BUTTONS     = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                reset,
    button_debouncer_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } state_t;

    logic [NUM_BUTTONS-1:0] r_s1;
    logic [NUM_BUTTONS-1:0] r_s2;
    logic [NUM_BUTTONS-1:0] w_r;

    state_t          r_state    [NUM_BUTTONS];
    logic [CW-1:0]   r_cnt      [NUM_BUTTONS];
    state_t          w_state_nx [NUM_BUTTONS];
    logic [CW-1:0]   w_cnt_nx   [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] r_pressed;
    logic [NUM_BUTTONS-1:0] r_released;
    logic [NUM_BUTTONS-1:0] r_held;
    logic [NUM_BUTTONS-1:0] w_pressed_nx;
    logic [NUM_BUTTONS-1:0] w_released_nx;
    logic [NUM_BUTTONS-1:0] w_held_nx;

    assign w_r = r_s2;

    // State register: synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_pressed  <= '0;
            r_released <= '0;
            r_held     <= '0;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                r_state[i] <= RELEASED;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_s1       <= ~bus.button_n;
            r_s2       <= r_s1;
            r_pressed  <= w_pressed_nx;
            r_released <= w_released_nx;
            r_held     <= w_held_nx;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
        end
    end

    // Next-state logic; the counter only advances below CNT_LAST so it never wraps.
    always_comb begin
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            unique case (r_state[i])
                RELEASED: begin
                    if (w_r[i]) begin
                        w_state_nx[i] = CONFIRM_PRESS;
                        w_cnt_nx[i]   = '0;
                    end
                end
                CONFIRM_PRESS: begin
                    if (!w_r[i])                 w_state_nx[i] = RELEASED;
                    else if (r_cnt[i] == CNT_LAST) w_state_nx[i] = PRESSED;
                    else                         w_cnt_nx[i]   = r_cnt[i] + 1'b1;
                end
                PRESSED: begin
                    if (!w_r[i]) begin
                        w_state_nx[i] = CONFIRM_RELEASE;
                        w_cnt_nx[i]   = '0;
                    end
                end
                CONFIRM_RELEASE: begin
                    if (w_r[i])                  w_state_nx[i] = PRESSED;
                    else if (r_cnt[i] == CNT_LAST) w_state_nx[i] = RELEASED;
                    else                         w_cnt_nx[i]   = r_cnt[i] + 1'b1;
                end
                default: begin
                    w_state_nx[i] = RELEASED;
                    w_cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    // Output logic; held follows the next state so it rises with the pressed pulse.
    always_comb begin
        w_pressed_nx  = '0;
        w_released_nx = '0;
        w_held_nx     = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            w_pressed_nx[i]  = (r_state[i] == CONFIRM_PRESS) && w_r[i] && (r_cnt[i] == CNT_LAST);
            w_released_nx[i] = (r_state[i] == CONFIRM_RELEASE) && !w_r[i] && (r_cnt[i] == CNT_LAST);
            w_held_nx[i]     = (w_state_nx[i] == PRESSED) || (w_state_nx[i] == CONFIRM_RELEASE);
        end
    end

    assign bus.pressed  = r_pressed;
    assign bus.released = r_released;
    assign bus.held     = r_held;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a run-length reference model checked every cycle.
module tb_button_debouncer;
    localparam int NB = 3;
    localparam int DC = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    button_debouncer_if #(.NUM_BUTTONS(NB)) bus_if ();

    button_debouncer #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    // Reference: two-sample delay, then the level flips once DC+1 consecutive
    // samples disagree with it; any agreeing sample restarts the run.
    logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_rel;
    int            m_run [NB];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            logic [NB-1:0] smp;
            smp     = m_d2;
            m_d2    = m_d1;
            m_d1    = ~bus_if.button_n;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NB; i++) begin
                if (smp[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC + 1) begin
                        m_level[i] = smp[i];
                        m_run[i]   = 0;
                        if (smp[i]) m_press[i] = 1'b1;
                        else        m_rel[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("model_pressed",  bus_if.pressed,  m_press);
            check("model_released", bus_if.released, m_rel);
            check("model_held",     bus_if.held,     m_level);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bus_if.button_n = 3'b111;
        #2;
        check("reset_pressed",  bus_if.pressed,  3'b000);
        check("reset_released", bus_if.released, 3'b000);
        check("reset_held",     bus_if.held,     3'b000);
        step(2);
        reset = 1'b0;
        step(5);
        check("idle_held", bus_if.held, 3'b000);

        // Channel 0 press, held 20 cycles
        bus_if.button_n = 3'b110;
        step(6);
        check("p0_before", bus_if.pressed, 3'b000);
        check("h0_before", bus_if.held,    3'b000);
        step(1);
        check("p0_edge6",  bus_if.pressed, 3'b001);
        check("h0_edge6",  bus_if.held,    3'b001);
        step(1);
        check("p0_after",  bus_if.pressed, 3'b000);
        step(12);
        check("h0_hold",   bus_if.held,    3'b001);

        // Channel 0 release
        bus_if.button_n = 3'b111;
        step(6);
        check("r0_before", bus_if.released, 3'b000);
        check("h0_still",  bus_if.held,     3'b001);
        step(1);
        check("r0_edge6",  bus_if.released, 3'b001);
        check("h0_fall",   bus_if.held,     3'b000);
        step(1);
        check("r0_after",  bus_if.released, 3'b000);

        // Channel 1 bounce
        bus_if.button_n = 3'b101; step(3);
        bus_if.button_n = 3'b111; step(1);
        bus_if.button_n = 3'b101; step(3);
        bus_if.button_n = 3'b111; step(8);
        check("bounce_h1", bus_if.held, 3'b000);

        // Channel 0 hold with a 2-cycle release glitch
        bus_if.button_n = 3'b110; step(10);
        check("g_held", bus_if.held, 3'b001);
        bus_if.button_n = 3'b111; step(2);
        bus_if.button_n = 3'b110; step(10);
        check("g_still", bus_if.held, 3'b001);
        bus_if.button_n = 3'b111; step(10);
        check("g_rel", bus_if.held, 3'b000);

        // All channels together, then reset while pressed
        bus_if.button_n = 3'b000;
        step(7);
        check("all_p", bus_if.pressed, 3'b111);
        check("all_h", bus_if.held,    3'b111);
        step(3);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_h", bus_if.held,    3'b000);
        check("rst_mid_p", bus_if.pressed, 3'b000);
        step(2);
        reset = 1'b0;
        step(6);
        check("post_p_before", bus_if.pressed, 3'b000);
        step(1);
        check("post_p", bus_if.pressed, 3'b111);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
